multi_cycle_execute_stage4: RTL and testbench
=============================================

# multi_cycle_execute_stage4

Floating-point add pipeline stage 4: per lane, handles significand carry-out from the stage 3 adder and computes the leading-zero normalization shift consumed by stage 5. Sits between multi_cycle_execute_stage3 (mx3) and multi_cycle_execute_stage5 (mx5). It has one register stage, squashes instructions on thread rollback, and handles zero and underflow results.

## Interface
- Parameters: none. Lane count comes from `VECTOR_LANES (16).
- clk  in  1  core clock; all state updates on posedge clk.
- reset  in  1  active-high, synchronous, sampled on posedge clk.
- mx3_instruction_valid  in  1  stage 3 holds a valid instruction.
- mx3_instruction  in  decoded_instruction_t  passed through.
- mx3_mask_value  in  `VECTOR_LANES  lane mask, passed through.
- mx3_thread_idx  in  thread_idx_t  passed through; also compared for rollback.
- mx3_subcycle  in  subcycle_t  passed through.
- mx3_sum  in  25 per lane  adder result; bit 24 is the carry.
- mx3_exponent  in  8 per lane  larger operand exponent.
- mx3_result_sign  in  1 per lane
- mx3_logical_subtract  in  1 per lane
- wb_rollback_en  in  1  rollback request from writeback.
- wb_rollback_thread_idx  in  thread_idx_t  thread being rolled back.
- mx4_instruction_valid, mx4_instruction, mx4_mask_value, mx4_thread_idx, mx4_subcycle  out  registered copies of the mx3 fields.
- mx4_significand  out  24 per lane
- mx4_exponent  out  8 per lane
- mx4_norm_shift  out  5 per lane
- mx4_result_sign, mx4_logical_subtract  out  1 per lane

## Operation
Each lane computes the following combinationally from its mx3 inputs:
- **Carry case**: applies when logical_subtract=0 and sum[24]=1.
  - significand=sum[24:1], exponent=mx3_exponent+1, norm_shift=0.
  - If the incremented exponent is 0xFF, force significand=0 to produce infinity.
- **No-carry add**: applies when logical_subtract=0 and sum[24]=0.
  - significand=sum[23:0], exponent unchanged, norm_shift=0.
- **Logical subtract**: lzc = count of leading zeros in sum[23:0], range 0..24. sum[24] is ignored because it is always 0 here.
  - significand=sum[23:0], exponent=mx3_exponent, norm_shift=lzc.
- **Zero result**: applies when logical_subtract=1 and sum[23:0]=0.
  - norm_shift=24 and exponent=24, so stage 5 produces exponent 0 and significand 0.
  - The zero result takes priority over the underflow handling in Configuration.
- **Pass-through**: sign, mask, instruction, thread and subcycle pass unmodified.
- **Rollback**:
  - If wb_rollback_en=1 and wb_rollback_thread_idx == mx3_thread_idx in the same cycle, mx4_instruction_valid is loaded with 0.
  - All other mx4 registers still load normally.
  - A rollback for a different thread has no effect.
- Lanes are fully independent. Masked-off lanes are computed anyway; mask gating happens at writeback.

## Timing
- Latency is exactly 1 cycle, mx3 to mx4. There are no stalls and no backpressure, so a new instruction is accepted every cycle.
- Reset: every mx4 output register is 0 on the first posedge with reset=1. This includes valid, instruction, mask, thread_idx, subcycle, significand, exponent, norm_shift, sign and logical_subtract.
- Reset asserted mid-stream drops the in-flight instruction. Valid is 0 in the cycle after reset is sampled.
- Reset has priority over rollback. Rollback has priority over mx3_instruction_valid.
- Data registers load even when mx3_instruction_valid=0. Consumers must qualify on valid.

## Configuration
- Macro: FP_DENORM_CLAMP_EN. It controls logical subtracts with a nonzero result where lzc >= mx3_exponent.
- **Defined** (gradual underflow): norm_shift = mx3_exponent (clamped, at most 24), so stage 5 produces exponent 0 with a partially normalized denormal significand.
- **Undefined** (flush to zero): significand=0, exponent=0, norm_shift=0.
- **lzc < exponent**: both builds behave identically.

## Test plan
- **Carry**: 1.0+1.0 with sum=0x1000000, exp=127, sub=0 -> significand=0x800000, exponent=128, norm_shift=0, valid 1 cycle later.
- **Normalize**: 1.5-1.0 with sum=0x0400000, exp=127, sub=1 -> norm_shift=1, exponent=127, significand=0x400000.
- **Zero**: 1.0-1.0 with sum=0, exp=127, sub=1 -> norm_shift=24, exponent=24, significand=0.
- **Underflow**: sum=0x000100, exp=3, sub=1, lzc=15.
  - With FP_DENORM_CLAMP_EN: norm_shift=3, exponent=3.
  - Without it: significand=0, exponent=0, norm_shift=0.
- **Rollback**: three back-to-back valid instructions on threads 2, 1, 2, with wb_rollback_en=1 and thread 2 in the third cycle -> mx4 valid reads 1, 1, 0. The third instruction's data fields still load.
- **Reset**: assert reset for 1 cycle while a valid carry-case instruction is in mx3 -> all mx4 outputs 0 next cycle. Normal results resume the cycle after reset deasserts.

Source files
------------

// File: rtl/multi_cycle_execute_stage4.sv
// multi_cycle_execute_stage4: FP add stage 4. Per lane, resolves the adder
// carry-out, computes the leading-zero normalization shift for stage 5, and
// handles zero and underflow results. One register stage; thread rollback
// squashes the valid bit only.
// Optional feature macro: FP_DENORM_CLAMP_EN (gradual underflow instead of
// flush-to-zero when lzc >= exponent on a logical subtract).

package mx4_types_pkg;
  typedef logic [31:0] decoded_instruction_t;
  typedef logic [1:0]  thread_idx_t;
  typedef logic [3:0]  subcycle_t;
endpackage

`ifndef VECTOR_LANES
`define VECTOR_LANES 16
`endif

module multi_cycle_execute_stage4
  import mx4_types_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                mx3_instruction_valid,
  input  decoded_instruction_t                mx3_instruction,
  input  logic [`VECTOR_LANES-1:0]            mx3_mask_value,
  input  thread_idx_t                         mx3_thread_idx,
  input  subcycle_t                           mx3_subcycle,
  input  logic [`VECTOR_LANES-1:0][24:0]      mx3_sum,
  input  logic [`VECTOR_LANES-1:0][7:0]       mx3_exponent,
  input  logic [`VECTOR_LANES-1:0]            mx3_result_sign,
  input  logic [`VECTOR_LANES-1:0]            mx3_logical_subtract,
  input  logic                                wb_rollback_en,
  input  thread_idx_t                         wb_rollback_thread_idx,
  output logic                                mx4_instruction_valid,
  output decoded_instruction_t                mx4_instruction,
  output logic [`VECTOR_LANES-1:0]            mx4_mask_value,
  output thread_idx_t                         mx4_thread_idx,
  output subcycle_t                           mx4_subcycle,
  output logic [`VECTOR_LANES-1:0][23:0]      mx4_significand,
  output logic [`VECTOR_LANES-1:0][7:0]       mx4_exponent,
  output logic [`VECTOR_LANES-1:0][4:0]       mx4_norm_shift,
  output logic [`VECTOR_LANES-1:0]            mx4_result_sign,
  output logic [`VECTOR_LANES-1:0]            mx4_logical_subtract
);

  localparam int unsigned NL = `VECTOR_LANES;

  // Leading-zero count of a 24-bit significand; returns 24 for all zeros.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] cnt;
    logic       found;
    cnt   = 5'd24;
    found = 1'b0;
    for (int unsigned b = 0; b < 24; b++) begin
      if (!found && v[23 - b]) begin
        cnt   = b[4:0];
        found = 1'b1;
      end
    end
    return cnt;
  endfunction

  logic                       valid_q, valid_d;
  decoded_instruction_t       instruction_q, instruction_d;
  logic [NL-1:0]              mask_q, mask_d;
  thread_idx_t                thread_q, thread_d;
  subcycle_t                  subcycle_q, subcycle_d;
  logic [NL-1:0][23:0]        sig_q, sig_d;
  logic [NL-1:0][7:0]         exp_q, exp_d;
  logic [NL-1:0][4:0]         shift_q, shift_d;
  logic [NL-1:0]              sign_q, sign_d;
  logic [NL-1:0]              lsub_q, lsub_d;

  logic [4:0]                 lzc;
  logic [7:0]                 exp_inc;

  // Next-state: control pass-through with rollback squash, and per-lane
  // carry / normalize / zero / underflow resolution.
  always_comb begin
    valid_d       = mx3_instruction_valid
                    && !(wb_rollback_en && wb_rollback_thread_idx == mx3_thread_idx);
    instruction_d = mx3_instruction;
    mask_d        = mx3_mask_value;
    thread_d      = mx3_thread_idx;
    subcycle_d    = mx3_subcycle;
    sign_d        = mx3_result_sign;
    lsub_d        = mx3_logical_subtract;
    sig_d         = '0;
    exp_d         = '0;
    shift_d       = '0;
    lzc           = '0;
    exp_inc       = '0;
    for (int unsigned i = 0; i < NL; i++) begin
      sig_d[i]   = mx3_sum[i][23:0];
      exp_d[i]   = mx3_exponent[i];
      shift_d[i] = '0;
      lzc        = lzc24(mx3_sum[i][23:0]);
      exp_inc    = mx3_exponent[i] + 8'd1;
      if (!mx3_logical_subtract[i]) begin
        if (mx3_sum[i][24]) begin
          exp_d[i] = exp_inc;
          sig_d[i] = (exp_inc == 8'hFF) ? 24'd0 : mx3_sum[i][24:1];
        end
      end else if (mx3_sum[i][23:0] == 24'd0) begin
        // Zero result wins over underflow: stage 5 subtracts 24 from 24.
        sig_d[i]   = '0;
        exp_d[i]   = 8'd24;
        shift_d[i] = 5'd24;
      end else if ({3'b000, lzc} >= mx3_exponent[i]) begin
`ifdef FP_DENORM_CLAMP_EN
        // Nonzero result implies lzc <= 23, so exponent already fits; clamp kept for safety.
        shift_d[i] = (mx3_exponent[i] > 8'd24) ? 5'd24 : mx3_exponent[i][4:0];
`else
        sig_d[i]   = '0;
        exp_d[i]   = '0;
        shift_d[i] = '0;
`endif
      end else begin
        shift_d[i] = lzc;
      end
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= 1'b0;
      instruction_q <= '0;
      mask_q        <= '0;
      thread_q      <= '0;
      subcycle_q    <= '0;
      sig_q         <= '0;
      exp_q         <= '0;
      shift_q       <= '0;
      sign_q        <= '0;
      lsub_q        <= '0;
    end else begin
      valid_q       <= valid_d;
      instruction_q <= instruction_d;
      mask_q        <= mask_d;
      thread_q      <= thread_d;
      subcycle_q    <= subcycle_d;
      sig_q         <= sig_d;
      exp_q         <= exp_d;
      shift_q       <= shift_d;
      sign_q        <= sign_d;
      lsub_q        <= lsub_d;
    end
  end

  assign mx4_instruction_valid = valid_q;
  assign mx4_instruction       = instruction_q;
  assign mx4_mask_value        = mask_q;
  assign mx4_thread_idx        = thread_q;
  assign mx4_subcycle          = subcycle_q;
  assign mx4_significand       = sig_q;
  assign mx4_exponent          = exp_q;
  assign mx4_norm_shift        = shift_q;
  assign mx4_result_sign       = sign_q;
  assign mx4_logical_subtract  = lsub_q;

endmodule

// File: tb/tb_multi_cycle_execute_stage4.sv
// Directed self-checking bench for multi_cycle_execute_stage4.
// Lane 0 carries the vector under test; all other lanes carry a fixed
// normalize case (shift 1) to show lanes stay independent.
`timescale 1ns/1ps
module tb_multi_cycle_execute_stage4;
  import mx4_types_pkg::*;

  localparam int unsigned NL   = `VECTOR_LANES;
  localparam int unsigned LAST = NL - 1;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        mx3_instruction_valid;
  decoded_instruction_t        mx3_instruction;
  logic [NL-1:0]               mx3_mask_value;
  thread_idx_t                 mx3_thread_idx;
  subcycle_t                   mx3_subcycle;
  logic [NL-1:0][24:0]         mx3_sum;
  logic [NL-1:0][7:0]          mx3_exponent;
  logic [NL-1:0]               mx3_result_sign;
  logic [NL-1:0]               mx3_logical_subtract;
  logic                        wb_rollback_en;
  thread_idx_t                 wb_rollback_thread_idx;
  logic                        mx4_instruction_valid;
  decoded_instruction_t        mx4_instruction;
  logic [NL-1:0]               mx4_mask_value;
  thread_idx_t                 mx4_thread_idx;
  subcycle_t                   mx4_subcycle;
  logic [NL-1:0][23:0]         mx4_significand;
  logic [NL-1:0][7:0]          mx4_exponent;
  logic [NL-1:0][4:0]          mx4_norm_shift;
  logic [NL-1:0]               mx4_result_sign;
  logic [NL-1:0]               mx4_logical_subtract;

  int unsigned checks = 0;
  int unsigned errors = 0;

  multi_cycle_execute_stage4 dut (
    .clk                    (clk),
    .reset                  (reset),
    .mx3_instruction_valid  (mx3_instruction_valid),
    .mx3_instruction        (mx3_instruction),
    .mx3_mask_value         (mx3_mask_value),
    .mx3_thread_idx         (mx3_thread_idx),
    .mx3_subcycle           (mx3_subcycle),
    .mx3_sum                (mx3_sum),
    .mx3_exponent           (mx3_exponent),
    .mx3_result_sign        (mx3_result_sign),
    .mx3_logical_subtract   (mx3_logical_subtract),
    .wb_rollback_en         (wb_rollback_en),
    .wb_rollback_thread_idx (wb_rollback_thread_idx),
    .mx4_instruction_valid  (mx4_instruction_valid),
    .mx4_instruction        (mx4_instruction),
    .mx4_mask_value         (mx4_mask_value),
    .mx4_thread_idx         (mx4_thread_idx),
    .mx4_subcycle           (mx4_subcycle),
    .mx4_significand        (mx4_significand),
    .mx4_exponent           (mx4_exponent),
    .mx4_norm_shift         (mx4_norm_shift),
    .mx4_result_sign        (mx4_result_sign),
    .mx4_logical_subtract   (mx4_logical_subtract)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane0(input logic [24:0] sum, input logic [7:0] exp,
                           input logic lsub, input logic sign);
    mx3_sum[0]              = sum;
    mx3_exponent[0]         = exp;
    mx3_logical_subtract[0] = lsub;
    mx3_result_sign[0]      = sign;
  endtask

  task automatic chk_lane0(input string tag, input logic [23:0] sig,
                           input logic [7:0] exp, input logic [4:0] sh);
    check({tag, ".sig"},   mx4_significand[0], sig);
    check({tag, ".exp"},   mx4_exponent[0],    exp);
    check({tag, ".shift"}, mx4_norm_shift[0],  sh);
  endtask

  task automatic chk_last(input string tag);
    check({tag, ".last.sig"},   mx4_significand[LAST], 32'h400000);
    check({tag, ".last.exp"},   mx4_exponent[LAST],    32'd127);
    check({tag, ".last.shift"}, mx4_norm_shift[LAST],  32'd1);
  endtask

  initial begin
    // Background lanes: normalize case 0x0400000, exp 127, subtract.
    for (int i = 0; i < int'(NL); i++) begin
      mx3_sum[i]              = 25'h0400000;
      mx3_exponent[i]         = 8'd127;
      mx3_logical_subtract[i] = 1'b1;
      mx3_result_sign[i]      = 1'b1;
    end
    reset                  = 1'b1;
    mx3_instruction_valid  = 1'b1;
    mx3_instruction        = 32'hDEADBEEF;
    mx3_mask_value         = '1;
    mx3_thread_idx         = 2'd3;
    mx3_subcycle           = 4'd9;
    wb_rollback_en         = 1'b0;
    wb_rollback_thread_idx = 2'd0;
    set_lane0(25'h1000000, 8'd127, 1'b0, 1'b1);

    // Reset state: every output register cleared.
    tick();
    check("rst.valid", mx4_instruction_valid, 0);
    check("rst.instr", mx4_instruction, 0);
    check("rst.mask",  mx4_mask_value, 0);
    check("rst.thr",   mx4_thread_idx, 0);
    check("rst.subc",  mx4_subcycle, 0);
    chk_lane0("rst", 24'd0, 8'd0, 5'd0);
    check("rst.sign",  mx4_result_sign, 0);
    check("rst.lsub",  mx4_logical_subtract, 0);
    check("rst.last.sig", mx4_significand[LAST], 0);

    // Carry: 1.0 + 1.0; valid must not appear before the edge.
    reset           = 1'b0;
    mx3_instruction = 32'h12345678;
    mx3_mask_value  = 16'hA5C3;
    mx3_thread_idx  = 2'd1;
    mx3_subcycle    = 4'd5;
    set_lane0(25'h1000000, 8'd127, 1'b0, 1'b1);
    #1;
    check("carry.prelat", mx4_instruction_valid, 0);
    tick();
    check("carry.valid", mx4_instruction_valid, 1);
    check("carry.instr", mx4_instruction, 32'h12345678);
    check("carry.mask",  mx4_mask_value, 32'hA5C3);
    check("carry.thr",   mx4_thread_idx, 1);
    check("carry.subc",  mx4_subcycle, 5);
    check("carry.sign0", mx4_result_sign[0], 1);
    check("carry.lsub0", mx4_logical_subtract[0], 0);
    check("carry.lsubL", mx4_logical_subtract[LAST], 1);
    chk_lane0("carry", 24'h800000, 8'd128, 5'd0);
    chk_last("carry");

    // Carry into exponent 0xFF forces infinity significand.
    set_lane0(25'h1FFFFFF, 8'hFE, 1'b0, 1'b0);
    tick();
    chk_lane0("inf", 24'd0, 8'hFF, 5'd0);
    check("inf.sign0", mx4_result_sign[0], 0);

    // Carry with exponent 0xFD stays finite.
    set_lane0(25'h1FFFFFF, 8'hFD, 1'b0, 1'b0);
    tick();
    chk_lane0("nearinf", 24'hFFFFFF, 8'hFE, 5'd0);

    // No-carry add.
    set_lane0(25'h0C00000, 8'd100, 1'b0, 1'b0);
    tick();
    chk_lane0("nocarry", 24'hC00000, 8'd100, 5'd0);

    // Normalize: 1.5 - 1.0.
    set_lane0(25'h0400000, 8'd127, 1'b1, 1'b0);
    tick();
    chk_lane0("norm", 24'h400000, 8'd127, 5'd1);

    // Already normalized subtract result: lzc 0.
    set_lane0(25'h0800001, 8'd50, 1'b1, 1'b0);
    tick();
    chk_lane0("norm0", 24'h800001, 8'd50, 5'd0);

    // Zero result: 1.0 - 1.0.
    set_lane0(25'h0000000, 8'd127, 1'b1, 1'b0);
    tick();
    chk_lane0("zero", 24'd0, 8'd24, 5'd24);

    // Zero result with tiny exponent: zero wins over underflow.
    set_lane0(25'h0000000, 8'd3, 1'b1, 1'b0);
    tick();
    chk_lane0("zerolow", 24'd0, 8'd24, 5'd24);

    // lzc (15) < exponent (20): same in both builds.
    set_lane0(25'h0000100, 8'd20, 1'b1, 1'b0);
    tick();
    chk_lane0("lzclt", 24'h000100, 8'd20, 5'd15);

    // Underflow: lzc 15, exponent 3; then boundary lzc == exponent == 15.
    set_lane0(25'h0000100, 8'd3, 1'b1, 1'b0);
    tick();
`ifdef FP_DENORM_CLAMP_EN
    chk_lane0("uflow", 24'h000100, 8'd3, 5'd3);
`else
    chk_lane0("uflow", 24'd0, 8'd0, 5'd0);
`endif
    set_lane0(25'h0000100, 8'd15, 1'b1, 1'b0);
    tick();
`ifdef FP_DENORM_CLAMP_EN
    chk_lane0("uflow.eq", 24'h000100, 8'd15, 5'd15);
`else
    chk_lane0("uflow.eq", 24'd0, 8'd0, 5'd0);
`endif
    set_lane0(25'h0000100, 8'd16, 1'b1, 1'b0);
    tick();
    chk_lane0("uflow.gt1", 24'h000100, 8'd16, 5'd15);

    // Rollback: threads 2, 1, 2 back-to-back, rollback of thread 2 in cycle 3.
    mx3_thread_idx = 2'd2;
    set_lane0(25'h0400000, 8'd127, 1'b1, 1'b0);
    tick();
    check("rb1.valid", mx4_instruction_valid, 1);
    mx3_thread_idx = 2'd1;
    tick();
    check("rb2.valid", mx4_instruction_valid, 1);
    mx3_thread_idx         = 2'd2;
    mx3_instruction        = 32'hCAFEF00D;
    wb_rollback_en         = 1'b1;
    wb_rollback_thread_idx = 2'd2;
    set_lane0(25'h0000100, 8'd20, 1'b1, 1'b0);
    tick();
    check("rb3.valid", mx4_instruction_valid, 0);
    check("rb3.instr", mx4_instruction, 32'hCAFEF00D);
    check("rb3.thr",   mx4_thread_idx, 2);
    chk_lane0("rb3", 24'h000100, 8'd20, 5'd15);

    // Rollback of a different thread does not squash.
    mx3_thread_idx = 2'd1;
    tick();
    check("rbother.valid", mx4_instruction_valid, 1);

    // Invalid input: valid stays low, data still loads.
    wb_rollback_en        = 1'b0;
    mx3_instruction_valid = 1'b0;
    set_lane0(25'h0C00000, 8'd100, 1'b0, 1'b0);
    tick();
    check("inv.valid", mx4_instruction_valid, 0);
    chk_lane0("inv", 24'hC00000, 8'd100, 5'd0);

    // Reset over a valid carry instruction, then resume.
    mx3_instruction_valid = 1'b1;
    mx3_thread_idx        = 2'd3;
    reset                 = 1'b1;
    set_lane0(25'h1000000, 8'd127, 1'b0, 1'b1);
    tick();
    check("midrst.valid", mx4_instruction_valid, 0);
    check("midrst.instr", mx4_instruction, 0);
    check("midrst.mask",  mx4_mask_value, 0);
    check("midrst.thr",   mx4_thread_idx, 0);
    check("midrst.sign",  mx4_result_sign, 0);
    chk_lane0("midrst", 24'd0, 8'd0, 5'd0);
    reset = 1'b0;
    tick();
    check("resume.valid", mx4_instruction_valid, 1);
    check("resume.thr",   mx4_thread_idx, 3);
    chk_lane0("resume", 24'h800000, 8'd128, 5'd0);
    chk_last("resume");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
